// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets and FSM states.
package intc_pkg;

  localparam int unsigned ID_W          = 3;
  localparam int unsigned CUR_VALID_BIT = 31;

  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_PEND = 2'd1;
  localparam logic [1:0] OFF_CFG  = 2'd2;
  localparam logic [1:0] OFF_CUR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 has the highest priority.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 6
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/config registers, priority
// selection and an assert/acknowledge/EOI request sequencer towards CP0.
module intc_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 6,
  parameter logic [31:0] BASE = 32'h0000_7f20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_byteen,
  output logic [31:0]     bus_rdata,
  output logic            irq_out,
  output logic [2:0]      irq_id,
  input  logic            irq_ack
);

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] cfg_q, cfg_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_dly_q, src_dly_d;
  logic            cur_valid_q, cur_valid_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  logic            irq_out_q, irq_out_d;
  state_e          state_q, state_d;

  logic            hit;
  logic [1:0]      off;
  logic            wr;
  logic            wr_lane0;
  logic            eoi;
  logic [NSRC-1:0] wlane;
  logic [NSRC-1:0] pend_view;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] id_onehot;
  logic            id_active;
  logic            any_active;
  logic [ID_W-1:0] sel;
  logic            unused_bits;

  assign hit       = (bus_addr[31:4] == BASE[31:4]);
  assign off       = bus_addr[3:2];
  assign wr        = hit && (bus_byteen != 4'b0000);
  assign wr_lane0  = wr && bus_byteen[0];
  assign eoi       = wr && (off == OFF_CUR);
  assign wlane     = bus_wdata[NSRC-1:0];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NSRC]};

  // Level sources mirror the live line; edge sources read the latched bit.
  assign pend_view = (pend_q & cfg_q) | (src_irq & ~cfg_q);
  assign active    = pend_view & mask_q;
  assign id_onehot = NSRC'(1) << irq_id_q;
  assign id_active = |(active & id_onehot);

  intc_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (active),
    .any (any_active),
    .idx (sel)
  );

  // Register file next-state: MASK/CFG writes, edge latching with W1C and ack clear.
  always_comb begin
    logic [NSRC-1:0] clr;
    mask_d    = mask_q;
    cfg_d     = cfg_q;
    src_dly_d = src_irq;
    clr       = '0;
    if (wr_lane0 && (off == OFF_MASK)) mask_d = wlane;
    if (wr_lane0 && (off == OFF_CFG))  cfg_d  = wlane;
    if (wr_lane0 && (off == OFF_PEND)) clr    = wlane;
    if ((state_q == ST_ASSERT) && irq_ack) clr = clr | id_onehot;
    // A new rising edge in the same cycle as a clear keeps the bit set.
    pend_d = ((pend_q & ~clr) | (src_irq & ~src_dly_q)) & cfg_q;
  end

  // Request sequencer next-state: no preemption before ack, no nesting in service.
  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    cur_valid_d = cur_valid_q;
    cur_id_d    = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_active) begin
          state_d  = ST_ASSERT;
          irq_id_d = sel;
        end
      end
      ST_ASSERT: begin
        if (irq_ack) begin
          state_d     = ST_SERVICE;
          cur_valid_d = 1'b1;
          cur_id_d    = irq_id_q;
        end else if (!id_active) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d     = ST_IDLE;
          cur_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_out_d = (state_d == ST_ASSERT);
  end

  // All controller state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      cfg_q       <= '0;
      pend_q      <= '0;
      src_dly_q   <= '0;
      cur_valid_q <= 1'b0;
      cur_id_q    <= '0;
      irq_id_q    <= '0;
      irq_out_q   <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      mask_q      <= mask_d;
      cfg_q       <= cfg_d;
      pend_q      <= pend_d;
      src_dly_q   <= src_dly_d;
      cur_valid_q <= cur_valid_d;
      cur_id_q    <= cur_id_d;
      irq_id_q    <= irq_id_d;
      irq_out_q   <= irq_out_d;
      state_q     <= state_d;
    end
  end

  // Combinational register read; misses return zero.
  always_comb begin
    bus_rdata = 32'h0;
    if (hit) begin
      case (off)
        OFF_MASK: bus_rdata = 32'(mask_q);
        OFF_PEND: bus_rdata = 32'(pend_view);
        OFF_CFG:  bus_rdata = 32'(cfg_q);
        default: begin
          bus_rdata[CUR_VALID_BIT] = cur_valid_q;
          bus_rdata[ID_W-1:0]      = cur_id_q;
        end
      endcase
    end
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_intc_ctrl.sv
// Bench for intc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_intc_ctrl;

  localparam int unsigned NSRC  = 6;
  localparam logic [31:0] BASE  = 32'h0000_7f20;
  localparam logic [7:0]  LANES = 8'h3f;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [3:0]      bus_byteen;
  logic [31:0]     bus_rdata;
  logic            irq_out;
  logic [2:0]      irq_id;
  logic            irq_ack;

  int checks = 0;
  int errors = 0;

  // Model: 8-wide bit vectors per source, request/service flags, CUR contents.
  logic [7:0] m_mask, m_cfg, m_pend, m_srcd;
  logic       m_req, m_svc, m_cur_valid;
  logic [2:0] m_id, m_cur_id;

  intc_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_irq    (src_irq),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] src8, pv;
    src8 = 8'(src_irq);
    for (int i = 0; i < 8; i++) pv[i] = m_cfg[i] ? m_pend[i] : src8[i];
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0: return 32'(m_mask);
      2'd1: return 32'(pv);
      2'd2: return 32'(m_cfg);
      default: return {m_cur_valid, 28'h0, m_cur_id};
    endcase
  endfunction

  // One clock: evaluate the model on the pre-edge inputs, then sample #1 after the edge.
  task automatic tick();
    logic [7:0] src8, pv, act, lane, n_mask, n_cfg, n_pend;
    logic       wr0, eoi, n_req, n_svc, n_cv;
    logic [2:0] n_id, n_cid;
    int         sel;
    src8 = 8'(src_irq);
    for (int i = 0; i < 8; i++) pv[i] = m_cfg[i] ? m_pend[i] : src8[i];
    act = pv & m_mask;
    sel = -1;
    for (int i = 0; i < 8; i++) if (act[i] && sel < 0) sel = i;
    wr0  = (bus_addr[31:4] == BASE[31:4]) && bus_byteen[0];
    eoi  = (bus_addr[31:4] == BASE[31:4]) && (bus_byteen != 4'b0) && (bus_addr[3:2] == 2'd3);
    lane = bus_wdata[7:0] & LANES;
    n_mask = (wr0 && bus_addr[3:2] == 2'd0) ? lane : m_mask;
    n_cfg  = (wr0 && bus_addr[3:2] == 2'd2) ? lane : m_cfg;
    n_pend = m_pend;
    if (wr0 && bus_addr[3:2] == 2'd1) n_pend = n_pend & ~lane;
    if (m_req && irq_ack) n_pend[m_id] = 1'b0;
    n_pend = (n_pend | (src8 & ~m_srcd)) & m_cfg;
    n_req = m_req; n_svc = m_svc; n_id = m_id; n_cv = m_cur_valid; n_cid = m_cur_id;
    if (m_req) begin
      if (irq_ack) begin
        n_req = 1'b0; n_svc = 1'b1; n_cv = 1'b1; n_cid = m_id;
      end else if (!act[m_id]) begin
        n_req = 1'b0;
      end
    end else if (m_svc) begin
      if (eoi) begin n_svc = 1'b0; n_cv = 1'b0; end
    end else if (sel >= 0) begin
      n_req = 1'b1; n_id = 3'(sel);
    end
    @(posedge clk);
    if (reset) begin
      m_mask = 0; m_cfg = 0; m_pend = 0; m_srcd = 0;
      m_req = 0; m_svc = 0; m_id = 0; m_cur_valid = 0; m_cur_id = 0;
    end else begin
      m_mask = n_mask; m_cfg = n_cfg; m_pend = n_pend; m_srcd = src8;
      m_req = n_req; m_svc = n_svc; m_id = n_id; m_cur_valid = n_cv; m_cur_id = n_cid;
    end
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_addr = a; bus_wdata = d; bus_byteen = be;
    tick();
    bus_byteen = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out: got %b expected 0", irq_out); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_irq_id: got %0d expected 0", irq_id); end
    for (int r = 0; r < 4; r++) begin
      bus_addr = BASE + 32'(r * 4); #1;
      checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", r, bus_rdata); end
    end
  endtask

  task automatic test_edge_flow();
    bus_write(BASE + 32'h0, 32'h3f, 4'b0001);
    bus_write(BASE + 32'h8, 32'h01, 4'b0001);
    src_irq = 6'b000001; tick(); src_irq = '0;
    bus_addr = BASE + 32'h4; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata !== 32'h1) begin errors++; $display("FAIL edge_pend_n1: got irq_out=%b pend=%h expected 0/1", irq_out, bus_rdata); end
    tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL edge_assert_n2: got irq_out=%b id=%0d expected 1/0", irq_out, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    bus_addr = BASE + 32'hc; #1;
    checks++; if (bus_rdata !== 32'h8000_0000) begin errors++; $display("FAIL edge_cur_after_ack: got %h expected 80000000", bus_rdata); end
    bus_addr = BASE + 32'h4; #1;
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL edge_pend_cleared: got %h expected 0", bus_rdata); end
    bus_write(BASE + 32'hc, 32'h0, 4'b1111);
    bus_addr = BASE + 32'hc; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata[31] !== 1'b0) begin errors++; $display("FAIL edge_eoi: got irq_out=%b cur=%h expected 0/valid 0", irq_out, bus_rdata); end
  endtask

  task automatic test_level_priority();
    src_irq = 6'b001010; tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL level_prio: got irq_out=%b id=%0d expected 1/1", irq_out, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src_irq = 6'b001000;
    bus_write(BASE + 32'hc, 32'h0, 4'b0001);
    tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL level_next: got irq_out=%b id=%0d expected 1/3", irq_out, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src_irq = '0;
    bus_write(BASE + 32'hc, 32'h0, 4'b0001);
    tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL level_idle: got %b expected 0", irq_out); end
  endtask

  task automatic test_mask_gate();
    bus_write(BASE + 32'h0, 32'h00, 4'b0001);
    bus_write(BASE + 32'h8, 32'h04, 4'b0001);
    src_irq = 6'b000100; tick(); src_irq = '0;
    tick(); tick();
    bus_addr = BASE + 32'h4; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata !== 32'h4) begin errors++; $display("FAIL mask_gated: got irq_out=%b pend=%h expected 0/4", irq_out, bus_rdata); end
    bus_write(BASE + 32'h0, 32'h04, 4'b0001);
    tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL mask_open: got irq_out=%b id=%0d expected 1/2", irq_out, irq_id); end
  endtask

  task automatic test_w1c_cancel();
    bus_write(BASE + 32'h4, 32'h04, 4'b0001);
    tick();
    bus_addr = BASE + 32'h4; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata !== 32'h0) begin errors++; $display("FAIL w1c_cancel: got irq_out=%b pend=%h expected 0/0", irq_out, bus_rdata); end
    src_irq = 6'b000100; tick(); src_irq = '0; tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL w1c_reassert: got irq_out=%b id=%0d expected 1/2", irq_out, irq_id); end
    src_irq = 6'b000100;
    bus_write(BASE + 32'h4, 32'h04, 4'b0001);
    src_irq = '0;
    bus_addr = BASE + 32'h4; #1;
    checks++; if (bus_rdata !== 32'h4) begin errors++; $display("FAIL w1c_set_wins: got pend=%h expected 4", bus_rdata); end
    tick();
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL w1c_still_assert: got %b expected 1", irq_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    bus_write(BASE + 32'hc, 32'h0, 4'b0001);
    tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL w1c_cleanup: got %b expected 0", irq_out); end
  endtask

  task automatic test_service_no_nest();
    bus_write(BASE + 32'h0, 32'h3f, 4'b0001);
    bus_write(BASE + 32'h8, 32'h3f, 4'b0001);
    src_irq = 6'b010000; tick(); src_irq = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src_irq = 6'b000001; tick(); src_irq = '0; tick(); tick();
    bus_addr = BASE + 32'h4; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata !== 32'h1) begin errors++; $display("FAIL svc_no_nest: got irq_out=%b pend=%h expected 0/1", irq_out, bus_rdata); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    bus_addr = BASE + 32'hc; #1;
    checks++; if (irq_out !== 1'b0 || bus_rdata !== 32'h8000_0004) begin errors++; $display("FAIL svc_extra_ack: got irq_out=%b cur=%h expected 0/80000004", irq_out, bus_rdata); end
    bus_addr = BASE + 32'h4; #1;
    checks++; if (bus_rdata !== 32'h1) begin errors++; $display("FAIL svc_ack_keeps_pend: got %h expected 1", bus_rdata); end
    bus_write(BASE + 32'hc, 32'h0, 4'b0001);
    tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL svc_eoi_next: got irq_out=%b id=%0d expected 1/0", irq_out, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    bus_write(BASE + 32'hc, 32'h0, 4'b0001);
  endtask

  task automatic test_bus_edges();
    bus_write(BASE + 32'h0, 32'h00, 4'b0010);
    bus_addr = BASE + 32'h0; #1;
    checks++; if (bus_rdata !== 32'h3f) begin errors++; $display("FAIL lane1_write: got mask=%h expected 3f", bus_rdata); end
    bus_addr = BASE + 32'h10; #1;
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL miss_above: got %h expected 0", bus_rdata); end
    bus_addr = BASE | 32'h0001_0000; #1;
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL miss_high: got %h expected 0", bus_rdata); end
    src_irq = 6'b000010; tick(); src_irq = '0; tick();
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL pre_reset_assert: got irq_out=%b id=%0d expected 1/1", irq_out, irq_id); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (irq_out !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL reset_in_assert: got irq_out=%b id=%0d expected 0/0", irq_out, irq_id); end
    for (int r = 0; r < 4; r++) begin
      bus_addr = BASE + 32'(r * 4); #1;
      checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_in_assert_reg%0d: got %h expected 0", r, bus_rdata); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      src_irq = src_irq ^ NSRC'($urandom & $urandom & $urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus_addr   = BASE | 32'($urandom_range(0, 3) << 2);
        bus_wdata  = $urandom;
        bus_byteen = 4'($urandom);
      end else begin
        bus_addr   = $urandom;
        bus_byteen = 4'($urandom);
      end
      tick();
      bus_byteen = 4'b0; reset = 1'b0; irq_ack = 1'b0;
      checks++; if (irq_out !== m_req || irq_id !== m_id) begin errors++; $display("FAIL rand_irq[%0d]: got out=%b id=%0d expected out=%b id=%0d", n, irq_out, irq_id, m_req, m_id); end
      bus_addr = ($urandom_range(0, 4) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 3) << 2));
      #1;
      checks++; if (bus_rdata !== exp_read(bus_addr)) begin errors++; $display("FAIL rand_read[%0d]: addr=%h got %h expected %h", n, bus_addr, bus_rdata, exp_read(bus_addr)); end
    end
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; bus_addr = '0; bus_wdata = '0; bus_byteen = '0; irq_ack = 1'b0;
    m_mask = 0; m_cfg = 0; m_pend = 0; m_srcd = 0;
    m_req = 0; m_svc = 0; m_id = 0; m_cur_valid = 0; m_cur_id = 0;
    #2;
    test_reset();
    test_edge_flow();
    test_level_priority();
    test_mask_gate();
    test_w1c_cancel();
    test_service_no_nest();
    test_bus_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
